fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's 7-bit word address. It captures the returned 32-bit word into an IF/ID pipeline register with a valid bit. It handles stall, branch, jump, jump-register redirects and HALT detection, and counts issued instructions.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address,
// and fills the IF/ID register. Handles redirects, stall, HALT and issue counting.
//
// state  | meaning
// RUN    | fetching; redirects, stall and HALT detection are active
// HALTED | HALT_OP seen; only reset leaves this state
module fetch_unit #(
  parameter int          ADDR_W  = 7,
  parameter int          DATA_W  = 32,
  parameter logic [5:0]  HALT_OP = 6'b111111,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchBase,
  input  logic [15:0]       branchOffset,
  input  logic              jump,
  input  logic [25:0]       jumpTarget,
  input  logic              jumpReg,
  input  logic [31:0]       regTarget,
  output logic [ADDR_W-1:0] adrx,
  input  logic [DATA_W-1:0] instrIn,
  output logic [DATA_W-1:0] instrOut,
  output logic [ADDR_W-1:0] pcPlus1Out,
  output logic              validOut,
  output logic              halted,
  output logic [CNT_W-1:0]  issueCount
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   pc1_q, pc1_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                redirect;
  logic [ADDR_W-1:0]   target;

  // Only the low ADDR_W bits of each target field are meaningful.
  logic unused_hi;
  assign unused_hi = ^{jumpTarget[25:ADDR_W], regTarget[31:ADDR_W],
                       branchOffset[15:ADDR_W]};

  assign redirect = jumpReg | jump | branchTaken;

  always_comb begin
    target = branchBase + branchOffset[ADDR_W-1:0];
    if (jumpReg)   target = regTarget[ADDR_W-1:0];
    else if (jump) target = jumpTarget[ADDR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      if (redirect) begin
        pc_d    = target;
        instr_d = '0;
        pc1_d   = '0;
        valid_d = 1'b0;
      end else if (stall) begin
        pc_d = pc_q;
      end else if (instrIn[DATA_W-1 -: 6] == HALT_OP) begin
        state_d = HALTED;
        instr_d = '0;
        valid_d = 1'b0;
      end else begin
        instr_d = instrIn;
        pc1_d   = pc_q + PC_ONE;
        pc_d    = pc_q + PC_ONE;
        valid_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign adrx       = pc_q;
  assign instrOut   = instr_q;
  assign pcPlus1Out = pc1_q;
  assign validOut   = valid_q;
  assign halted     = (state_q == HALTED);
  assign issueCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, all checked
// every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset, stall, branchTaken, jump, jumpReg;
  logic [ADDR_W-1:0] branchBase;
  logic [15:0]       branchOffset;
  logic [25:0]       jumpTarget;
  logic [31:0]       regTarget;
  logic [ADDR_W-1:0] adrx, pcPlus1Out;
  logic [DATA_W-1:0] instrIn, instrOut;
  logic              validOut, halted;
  logic [CNT_W-1:0]  issueCount;

  logic [31:0] mem [DEPTH];
  int total = 0, passed = 0, failed = 0;

  // Reference model state
  int          m_pc, m_p1, m_cnt;
  logic [31:0] m_instr;
  logic        m_valid, m_halt;

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_OP(6'b111111), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken),
    .branchBase(branchBase), .branchOffset(branchOffset), .jump(jump),
    .jumpTarget(jumpTarget), .jumpReg(jumpReg), .regTarget(regTarget),
    .adrx(adrx), .instrIn(instrIn), .instrOut(instrOut), .pcPlus1Out(pcPlus1Out),
    .validOut(validOut), .halted(halted), .issueCount(issueCount)
  );

  always #5 clk = ~clk;
  assign instrIn = mem[adrx];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int t;
    if (reset) begin
      m_pc = 0; m_p1 = 0; m_cnt = 0; m_instr = 0; m_valid = 0; m_halt = 0;
    end else if (!m_halt) begin
      if (jumpReg || jump || branchTaken) begin
        if (jumpReg)   t = int'(regTarget % 128);
        else if (jump) t = int'(jumpTarget % 128);
        else begin
          t = int'(branchBase) + int'($signed(branchOffset));
          t = ((t % DEPTH) + DEPTH) % DEPTH;
        end
        m_pc = t; m_instr = 0; m_p1 = 0; m_valid = 0;
      end else if (!stall) begin
        if ((mem[m_pc] >> 26) == 32'd63) begin
          m_halt = 1; m_instr = 0; m_valid = 0;
        end else begin
          m_instr = mem[m_pc];
          m_pc    = (m_pc + 1) % DEPTH;
          m_p1    = m_pc;
          m_valid = 1;
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("adrx",       32'(adrx),       32'(m_pc));
    chk("instrOut",   instrOut,        m_instr);
    chk("pcPlus1Out", 32'(pcPlus1Out), 32'(m_p1));
    chk("validOut",   32'(validOut),   32'(m_valid));
    chk("halted",     32'(halted),     32'(m_halt));
    chk("issueCount", 32'(issueCount), 32'(m_cnt));
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; branchTaken = 0; jump = 0; jumpReg = 0;
    branchBase = '0; branchOffset = '0; jumpTarget = '0; regTarget = '0;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'(k) + 32'h100;
    idle_inputs();
    reset = 1;
    cycle(); cycle();
    chk("rst_adrx", 32'(adrx), 32'd0);
    chk("rst_valid", 32'(validOut), 32'd0);
    reset = 0;

    // Free run from address 0
    repeat (4) cycle();
    chk("run_adrx", 32'(adrx), 32'd4);
    chk("run_instr", instrOut, 32'h103);
    chk("run_cnt", 32'(issueCount), 32'd4);

    // Stall holds everything
    stall = 1; cycle(); cycle(); stall = 0;
    chk("stall_adrx", 32'(adrx), 32'd4);
    cycle(); cycle();

    // Backward branch: 5 + (-3) = 2
    branchTaken = 1; branchBase = 7'd5; branchOffset = 16'hFFFD;
    cycle(); branchTaken = 0;
    chk("br_adrx", 32'(adrx), 32'd2);
    chk("br_bubble", 32'(validOut), 32'd0);
    cycle();
    chk("br_issue", instrOut, 32'h102);

    // Wrapping branch: 126 + 4 = 2
    branchTaken = 1; branchBase = 7'd126; branchOffset = 16'd4;
    cycle(); branchTaken = 0;
    chk("brwrap_adrx", 32'(adrx), 32'd2);

    // JR beats J
    jump = 1; jumpTarget = 26'h74; jumpReg = 1; regTarget = 32'h2;
    cycle(); jumpReg = 0;
    chk("jr_adrx", 32'(adrx), 32'd2);
    cycle(); jump = 0;
    chk("j_adrx", 32'(adrx), 32'd116);
    cycle();
    stall = 1; jump = 1; jumpTarget = 26'h3;
    cycle(); stall = 0; jump = 0;
    chk("stallj_adrx", 32'(adrx), 32'd3);

    // Wrap of sequential PC
    jump = 1; jumpTarget = 26'd126; cycle(); jump = 0;
    repeat (3) cycle();

    // HALT at word 6, inputs ignored while halted
    mem[6] = 32'hFC00_0000;
    jump = 1; jumpTarget = 26'd6; cycle(); jump = 0;
    cycle();
    chk("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      branchTaken = i[0]; jump = i[1]; jumpTarget = 26'd20;
      branchBase = 7'd40; stall = i[2];
      cycle();
    end
    idle_inputs();
    chk("halt_adrx", 32'(adrx), 32'd6);
    reset = 1; cycle(); reset = 0;
    chk("halt_rst", 32'(halted), 32'd0);

    // Redirect cancels HALT fetched in the same cycle
    jump = 1; jumpTarget = 26'd6; cycle();
    jumpTarget = 26'd20; cycle(); jump = 0;
    chk("nohalt", 32'(halted), 32'd0);
    chk("nohalt_adrx", 32'(adrx), 32'd20);

    // Long run to saturate the narrow counter
    repeat (20) cycle();
    chk("sat_cnt", 32'(issueCount), 32'(CNT_MAX));

    // Random traffic
    for (int k = 0; k < DEPTH; k++) begin
      mem[k] = $urandom;
      if ($urandom_range(0, 15) == 0) mem[k][31:26] = 6'h3F;
    end
    for (int n = 0; n < 1500; n++) begin
      reset        = ($urandom_range(0, 60) == 0);
      stall        = ($urandom_range(0, 5) == 0);
      branchTaken  = ($urandom_range(0, 9) == 0);
      jump         = ($urandom_range(0, 14) == 0);
      jumpReg      = ($urandom_range(0, 19) == 0);
      branchBase   = 7'($urandom);
      branchOffset = 16'($urandom);
      jumpTarget   = 26'($urandom);
      regTarget    = $urandom;
      cycle();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
